fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares one fifo write port (datain/wr_in/full_out) between N independent producers, e.g. several status sources feeding a single UART TX fifo.
- Round-robin arbitration with burst lock: a granted requester keeps the port until it transfers a beat flagged last.
- Sits directly in front of the fifo instance.
- Per-requester valid/ready handshake, so producers never see fifo full_out directly.

Parameters:
- WIDTH, 8, data width per beat; matches the fifo WIDTH.
- N, 4, number of requesters; legal range 2..16.
- TIMEOUT, 64, watchdog stall limit in cycles; used only with FIFO_ARB_WATCHDOG_EN.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- req_valid_in  input  N  bit i: requester i presents a beat.
- req_data_in  input  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_last_in  input  N  bit i: current beat of requester i ends its burst.
- req_ready_out  output  N  bit i: beat of requester i accepted this cycle when valid.
- fifo_data_out  output  WIDTH  to fifo datain.
- fifo_wr_out  output  1  to fifo wr_in.
- fifo_full_in  input  1  from fifo full_out.
- busy_out  output  1  high while a requester holds the lock.
- owner_out  output  $clog2(N)  index of the current or most recent owner.
- wdt_err_out  output  1  sticky watchdog error; constant 0 without FIFO_ARB_WATCHDOG_EN.

Behaviour:
- Reset (asynchronous assert, synchronous use after release):
  - State IDLE, owner=0, rr pointer=0.
  - busy_out=0, req_ready_out=0, fifo_wr_out=0, wdt_err_out=0.
  - fifo_data_out is don't-care.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If any req_valid_in bit is set, select the first set bit searching upward from the rr pointer, wrapping modulo N.
  - Register the selection as owner and go to LOCKED next cycle.
  - No beat is transferred in IDLE; arbitration costs 1 cycle.
  - If no bit is set, stay in IDLE.
- LOCKED:
  - req_ready_out[owner] = !fifo_full_in. All other ready bits are 0. This is combinational from fifo_full_in.
  - A transfer occurs when req_valid_in[owner] && req_ready_out[owner].
  - fifo_wr_out = transfer, combinational. fifo_data_out = owner slice of req_data_in, combinational mux.
  - Transfer with req_last_in[owner]=1: go to IDLE and set rr pointer = owner+1, wrapping N-1 to 0.
  - Otherwise stay LOCKED.
- Owner deasserts valid mid-burst: lock is held with no writes and no timeout unless the watchdog is compiled in.
- fifo full: ready stays low and beats stall. Data is never dropped and fifo_wr_out is never asserted while fifo_full_in=1.
- Simultaneous requests: the rr order guarantees that each of N continuously requesting producers is granted within N arbitrations.
- Single requester: back-to-back bursts are separated by exactly 1 IDLE cycle.
- Reset mid-burst:
  - Outputs return to reset values immediately.
  - The partial burst is already in the fifo. The producer is responsible for recovery.
- busy_out = (state==LOCKED). owner_out holds its value through IDLE.

Optional Feature:
- Macro: FIFO_ARB_WATCHDOG_EN.
- Defined:
  - A stall counter runs in LOCKED while req_valid_in[owner]=0. It clears on any owner valid, and while fifo_full_in=1.
  - When the counter reaches TIMEOUT, force IDLE, set rr pointer = owner+1, and set wdt_err_out=1.
  - wdt_err_out is sticky until reset.
- Not defined: no counter is present, wdt_err_out is tied to 0, and the lock is held indefinitely.

Test Plan:
- N=4, WIDTH=8. req 2 sends 3-beat burst 0xA1,0xA2,0xA3 (last on 3rd), fifo not full -> arbitration cycle, then fifo_wr_out high 3 consecutive cycles with those data; busy_out falls after the 3rd beat; owner_out=2.
- All four requesters hold continuous 1-beat bursts (last=1) from reset -> write order 0,1,2,3,0,1,... with one IDLE cycle between grants.
- req 1 bursting while req 3 requests -> req_ready_out[3] stays 0 until req 1 last beat; req 3 is granted next even though req 0 also raises valid meanwhile.
- fifo_full_in=1 for 5 cycles during req 0 burst -> req_ready_out[0]=0 and fifo_wr_out=0 for those cycles; beat sequence resumes intact afterwards.
- rst_in pulled low mid-burst between clock edges -> req_ready_out, fifo_wr_out, busy_out drop to 0 without waiting for CLK; after release the next grant searches from 0.
- FIFO_ARB_WATCHDOG_EN, TIMEOUT=64: owner 1 drops valid mid-burst for 64 cycles -> IDLE, wdt_err_out=1, waiting req 2 granted next; without the macro, lock held and wdt_err_out=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one fifo write port among N producers.
// Optional stall watchdog compiled in with FIFO_ARB_WATCHDOG_EN.
module fifo_wr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 rst_in,
    input  logic [N-1:0]         req_valid_in,
    input  logic [N*WIDTH-1:0]   req_data_in,
    input  logic [N-1:0]         req_last_in,
    output logic [N-1:0]         req_ready_out,
    output logic [WIDTH-1:0]     fifo_data_out,
    output logic                 fifo_wr_out,
    input  logic                 fifo_full_in,
    output logic                 busy_out,
    output logic [$clog2(N)-1:0] owner_out,
    output logic                 wdt_err_out
);
    localparam int OW = $clog2(N);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [OW-1:0] sel, owner_inc;
    logic          found, own_valid, own_last, xfer, wdt_trip;

    // Owner-side mux: everything the locked requester presents.
    always_comb begin
        own_valid     = 1'b0;
        own_last      = 1'b0;
        fifo_data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                own_valid     = req_valid_in[i];
                own_last      = req_last_in[i];
                fifo_data_out = req_data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q == LOCKED && owner_q == OW'(i))
                req_ready_out[i] = !fifo_full_in;
        end
    end

    assign xfer        = (state_q == LOCKED) && own_valid && !fifo_full_in;
    assign fifo_wr_out = xfer;
    assign busy_out    = (state_q == LOCKED);
    assign owner_out   = owner_q;
    assign owner_inc   = (owner_q == OW'(N-1)) ? '0 : owner_q + 1'b1;

    // Descending offset scan so the nearest requester at or above rr wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = N-1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid_in[i] && ((int'(rr_q) + k) % N) == i) begin
                    found = 1'b1;
                    sel   = OW'(i);
                end
            end
        end
    end

`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    always_comb begin
        cnt_d    = cnt_q;
        wdt_trip = 1'b0;
        if (state_q != LOCKED || own_valid || fifo_full_in) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            wdt_trip = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | wdt_trip;
        end
    end

    assign wdt_err_out = err_q;
`else
    assign wdt_trip    = 1'b0;
    assign wdt_err_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = sel;
                    state_d = LOCKED;
                end
            end
            default: begin
                if ((xfer && own_last) || wdt_trip) begin
                    state_d = IDLE;
                    rr_d    = owner_inc;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N=4, WIDTH=8); honours FIFO_ARB_WATCHDOG_EN if defined.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic             CLK;
    logic             rst_in;
    logic [N-1:0]     req_valid_in;
    logic [N*WIDTH-1:0] req_data_in;
    logic [N-1:0]     req_last_in;
    logic [N-1:0]     req_ready_out;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_wr_out;
    logic             fifo_full_in;
    logic             busy_out;
    logic [1:0]       owner_out;
    logic             wdt_err_out;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .N(N), .TIMEOUT(64)) dut (
        .CLK(CLK), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_last_in(req_last_in),
        .req_ready_out(req_ready_out), .fifo_data_out(fifo_data_out), .fifo_wr_out(fifo_wr_out),
        .fifo_full_in(fifo_full_in), .busy_out(busy_out), .owner_out(owner_out),
        .wdt_err_out(wdt_err_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst_in       = 1'b0;
        req_valid_in = '0;
        req_data_in  = '0;
        req_last_in  = '0;
        fifo_full_in = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (req_ready_out !== 4'b0000) begin n_err++; $display("FAIL rst_ready got=%b exp=0000", req_ready_out); end
        n_vec++; if (fifo_wr_out !== 1'b0) begin n_err++; $display("FAIL rst_wr got=%b exp=0", fifo_wr_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy_out); end
        n_vec++; if (owner_out !== 2'd0) begin n_err++; $display("FAIL rst_owner got=%0d exp=0", owner_out); end
        n_vec++; if (wdt_err_out !== 1'b0) begin n_err++; $display("FAIL rst_wdt got=%b exp=0", wdt_err_out); end
    endtask

    task automatic test_burst();
        logic [7:0] beats [3];
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        do_reset();
        req_valid_in = 4'b0100;
        req_data_in[2*WIDTH +: WIDTH] = beats[0];
        #1;
        n_vec++; if (fifo_wr_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL burst_arb wr=%b busy=%b exp=0 0", fifo_wr_out, busy_out); end
        tick();
        for (int b = 0; b < 3; b++) begin
            req_data_in[2*WIDTH +: WIDTH] = beats[b];
            req_last_in = (b == 2) ? 4'b0100 : 4'b0000;
            #1;
            n_vec++; if (fifo_wr_out !== 1'b1 || fifo_data_out !== beats[b]) begin n_err++; $display("FAIL burst_beat%0d wr=%b data=%h exp=1 %h", b, fifo_wr_out, fifo_data_out, beats[b]); end
            n_vec++; if (req_ready_out !== 4'b0100 || owner_out !== 2'd2 || busy_out !== 1'b1) begin n_err++; $display("FAIL burst_ctl%0d ready=%b owner=%0d busy=%b exp=0100 2 1", b, req_ready_out, owner_out, busy_out); end
            tick();
        end
        req_valid_in = '0;
        req_last_in  = '0;
        #1;
        n_vec++; if (busy_out !== 1'b0 || fifo_wr_out !== 1'b0 || owner_out !== 2'd2) begin n_err++; $display("FAIL burst_end busy=%b wr=%b owner=%0d exp=0 0 2", busy_out, fifo_wr_out, owner_out); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) req_data_in[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
        req_valid_in = 4'b1111;
        req_last_in  = 4'b1111;
        #1;
        for (int g = 0; g < 8; g++) begin
            n_vec++; if (fifo_wr_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL rr_idle%0d wr=%b busy=%b exp=0 0", g, fifo_wr_out, busy_out); end
            tick();
            n_vec++; if (fifo_wr_out !== 1'b1 || owner_out !== 2'(g % 4) || fifo_data_out !== 8'(8'h10 + (g % 4))) begin
                n_err++; $display("FAIL rr_grant%0d wr=%b owner=%0d data=%h exp=1 %0d %h", g, fifo_wr_out, owner_out, fifo_data_out, g % 4, 8'(8'h10 + (g % 4)));
            end
            tick();
        end
        req_valid_in = '0;
        req_last_in  = '0;
    endtask

    task automatic test_burst_lock();
        do_reset();
        req_valid_in = 4'b0010;
        req_data_in[1*WIDTH +: WIDTH] = 8'h31;
        req_data_in[3*WIDTH +: WIDTH] = 8'h3D;
        tick();
        req_valid_in = 4'b1010;
        #1;
        n_vec++; if (req_ready_out !== 4'b0010 || fifo_data_out !== 8'h31) begin n_err++; $display("FAIL lock_b0 ready=%b data=%h exp=0010 31", req_ready_out, fifo_data_out); end
        tick();
        req_valid_in = 4'b1011;
        req_data_in[1*WIDTH +: WIDTH] = 8'h32;
        #1;
        n_vec++; if (req_ready_out !== 4'b0010 || fifo_data_out !== 8'h32) begin n_err++; $display("FAIL lock_b1 ready=%b data=%h exp=0010 32", req_ready_out, fifo_data_out); end
        tick();
        req_data_in[1*WIDTH +: WIDTH] = 8'h33;
        req_last_in = 4'b0010;
        #1;
        n_vec++; if (req_ready_out !== 4'b0010 || fifo_wr_out !== 1'b1) begin n_err++; $display("FAIL lock_b2 ready=%b wr=%b exp=0010 1", req_ready_out, fifo_wr_out); end
        tick();
        req_valid_in = 4'b1001;
        req_last_in  = 4'b0000;
        #1;
        n_vec++; if (busy_out !== 1'b0 || req_ready_out !== 4'b0000) begin n_err++; $display("FAIL lock_idle busy=%b ready=%b exp=0 0000", busy_out, req_ready_out); end
        tick();
        req_last_in = 4'b1000;
        #1;
        n_vec++; if (owner_out !== 2'd3 || req_ready_out !== 4'b1000 || fifo_data_out !== 8'h3D) begin n_err++; $display("FAIL lock_next owner=%0d ready=%b data=%h exp=3 1000 3d", owner_out, req_ready_out, fifo_data_out); end
        tick();
        req_valid_in = '0;
        req_last_in  = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid_in = 4'b0001;
        req_data_in[0 +: WIDTH] = 8'hB0;
        tick();
        #1;
        n_vec++; if (fifo_wr_out !== 1'b1 || fifo_data_out !== 8'hB0) begin n_err++; $display("FAIL full_b0 wr=%b data=%h exp=1 b0", fifo_wr_out, fifo_data_out); end
        tick();
        req_data_in[0 +: WIDTH] = 8'hB1;
        fifo_full_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (req_ready_out !== 4'b0000 || fifo_wr_out !== 1'b0) begin n_err++; $display("FAIL full_stall%0d ready=%b wr=%b exp=0000 0", c, req_ready_out, fifo_wr_out); end
            tick();
        end
        fifo_full_in = 1'b0;
        #1;
        n_vec++; if (fifo_wr_out !== 1'b1 || fifo_data_out !== 8'hB1 || req_ready_out !== 4'b0001) begin n_err++; $display("FAIL full_resume wr=%b data=%h ready=%b exp=1 b1 0001", fifo_wr_out, fifo_data_out, req_ready_out); end
        tick();
        req_data_in[0 +: WIDTH] = 8'hB2;
        req_last_in = 4'b0001;
        #1;
        n_vec++; if (fifo_wr_out !== 1'b1 || fifo_data_out !== 8'hB2) begin n_err++; $display("FAIL full_b2 wr=%b data=%h exp=1 b2", fifo_wr_out, fifo_data_out); end
        tick();
        req_valid_in = '0;
        req_last_in  = '0;
        #1;
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL full_end busy=%b exp=0", busy_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Complete a burst from requester 2 so the rr pointer moves to 3.
        req_valid_in = 4'b0100;
        req_last_in  = 4'b0100;
        tick();
        tick();
        req_valid_in = 4'b1000;
        req_last_in  = 4'b0000;
        tick();
        #1;
        n_vec++; if (owner_out !== 2'd3 || fifo_wr_out !== 1'b1) begin n_err++; $display("FAIL areset_pre owner=%0d wr=%b exp=3 1", owner_out, fifo_wr_out); end
        #1;
        rst_in = 1'b0;
        #1;
        n_vec++; if (req_ready_out !== 4'b0000 || fifo_wr_out !== 1'b0 || busy_out !== 1'b0 || owner_out !== 2'd0) begin
            n_err++; $display("FAIL areset_drop ready=%b wr=%b busy=%b owner=%0d exp=0000 0 0 0", req_ready_out, fifo_wr_out, busy_out, owner_out);
        end
        tick();
        rst_in = 1'b1;
        req_valid_in = 4'b1001;
        tick();
        #1;
        n_vec++; if (owner_out !== 2'd0 || busy_out !== 1'b1) begin n_err++; $display("FAIL areset_regrant owner=%0d busy=%b exp=0 1", owner_out, busy_out); end
        req_valid_in = '0;
    endtask

    task automatic test_stall_lock();
        do_reset();
        req_valid_in = 4'b0010;
        req_data_in[1*WIDTH +: WIDTH] = 8'h51;
        tick();
        tick();
        req_valid_in = 4'b0110;
        req_valid_in[1] = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            n_vec++; if (fifo_wr_out !== 1'b0) begin n_err++; $display("FAIL stall_wr%0d got=%b exp=0", c, fifo_wr_out); end
            tick();
        end
        #1;
`ifdef FIFO_ARB_WATCHDOG_EN
        n_vec++; if (busy_out !== 1'b0 || wdt_err_out !== 1'b1) begin n_err++; $display("FAIL stall_wdt busy=%b wdt=%b exp=0 1", busy_out, wdt_err_out); end
`else
        n_vec++; if (busy_out !== 1'b1 || wdt_err_out !== 1'b0 || req_ready_out !== 4'b0010) begin
            n_err++; $display("FAIL stall_hold busy=%b wdt=%b ready=%b exp=1 0 0010", busy_out, wdt_err_out, req_ready_out);
        end
        req_valid_in = 4'b0110;
        req_last_in  = 4'b0010;
        req_data_in[1*WIDTH +: WIDTH] = 8'h52;
        tick();
        req_valid_in = 4'b0100;
        req_last_in  = 4'b0000;
`endif
        tick();
        #1;
        n_vec++; if (owner_out !== 2'd2 || busy_out !== 1'b1) begin n_err++; $display("FAIL stall_next owner=%0d busy=%b exp=2 1", owner_out, busy_out); end
        req_valid_in = '0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_round_robin();
        test_burst_lock();
        test_full_stall();
        test_async_reset();
        test_stall_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
